// File: rtl/cam_pkg.sv
// Shared encodings for the CAM table controller: command ops, response status codes and
// controller states.
package cam_pkg;

   localparam logic OP_INSERT = 1'b0;
   localparam logic OP_DELETE = 1'b1;

   localparam logic [1:0] ST_INSERTED  = 2'd0;
   localparam logic [1:0] ST_EXISTS    = 2'd1;
   localparam logic [1:0] ST_FULL      = 2'd2;
   localparam logic [1:0] ST_NOT_FOUND = 2'd3;

   typedef enum logic [2:0] {
      StInit,
      StIdle,
      StLookup,
      StEval,
      StWrite,
      StWait,
      StResp
   } state_e;

endpackage

// File: rtl/cam_free_alloc.sv
// Free-entry allocator: lowest clear bit of the occupancy bitmap and a full flag.
module cam_free_alloc #(
   parameter int unsigned AddrW = 5
) (
   input  logic [(1 << AddrW)-1:0] bitmap_i,
   output logic [AddrW-1:0]        free_idx_o,
   output logic                    full_o
);

   logic any_free;

   priority_encoder #(
      .Width (1 << AddrW),
      .IdxW  (AddrW)
   ) u_enc (
      .in_i    (~bitmap_i),
      .idx_o   (free_idx_o),
      .valid_o (any_free)
   );

   assign full_o = ~any_free;

endmodule

// File: rtl/priority_encoder.sv
// Combinational priority encoder: index of the lowest set bit of in_i, plus a valid flag.
module priority_encoder #(
   parameter int unsigned Width = 32,
   parameter int unsigned IdxW  = $clog2(Width)
) (
   input  logic [Width-1:0] in_i,
   output logic [IdxW-1:0]  idx_o,
   output logic             valid_o
);

   // Scan from the top down so the lowest set bit is the last one written.
   always_comb begin
      idx_o   = '0;
      valid_o = 1'b0;
      for (int i = Width - 1; i >= 0; i--) begin
         if (in_i[i]) begin
            idx_o   = IdxW'(i);
            valid_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/cam_table_ctrl.sv
// Insert/delete request controller for the block-RAM CAM; owns the occupancy bitmap.
// Optional build macro CAM_CTRL_DUP_CHECK_EN enables duplicate-key detection on insert.
module cam_table_ctrl
   import cam_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] req_data,
   input  logic                  req_op,
   input  logic                  req_valid,
   output logic                  req_ready,
   output logic [ADDR_WIDTH-1:0] resp_addr,
   output logic [1:0]            resp_status,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [ADDR_WIDTH:0]   occupancy,
   output logic [ADDR_WIDTH-1:0] cam_write_addr,
   output logic [DATA_WIDTH-1:0] cam_write_data,
   output logic                  cam_write_delete,
   output logic                  cam_write_enable,
   input  logic                  cam_write_busy,
   output logic [DATA_WIDTH-1:0] cam_compare_data,
   input  logic                  cam_match,
   input  logic [ADDR_WIDTH-1:0] cam_match_addr
);

   localparam int unsigned Depth = 1 << ADDR_WIDTH;
   localparam int unsigned OccW  = ADDR_WIDTH + 1;

   state_e                state_q;
   logic [DATA_WIDTH-1:0] key_q;
   logic                  op_q;
   logic [Depth-1:0]      bitmap_q;
   logic [OccW-1:0]       occupancy_q;
   logic                  wait_first_q;
   logic                  req_ready_q;
   logic                  resp_valid_q;
   logic [1:0]            resp_status_q;
   logic [ADDR_WIDTH-1:0] resp_addr_q;
   logic [ADDR_WIDTH-1:0] write_addr_q;
   logic [DATA_WIDTH-1:0] write_data_q;
   logic                  write_delete_q;
   logic                  write_enable_q;
   logic [DATA_WIDTH-1:0] compare_data_q;

   logic [ADDR_WIDTH-1:0] free_idx;
   logic                  full;
   logic                  dup_hit;

   cam_free_alloc #(
      .AddrW (ADDR_WIDTH)
   ) u_alloc (
      .bitmap_i   (bitmap_q),
      .free_idx_o (free_idx),
      .full_o     (full)
   );

`ifdef CAM_CTRL_DUP_CHECK_EN
   assign dup_hit = cam_match;
`else
   assign dup_hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= StInit;
         key_q          <= '0;
         op_q           <= OP_INSERT;
         bitmap_q       <= '0;
         occupancy_q    <= '0;
         wait_first_q   <= 1'b0;
         req_ready_q    <= 1'b0;
         resp_valid_q   <= 1'b0;
         resp_status_q  <= ST_INSERTED;
         resp_addr_q    <= '0;
         write_addr_q   <= '0;
         write_data_q   <= '0;
         write_delete_q <= 1'b0;
         write_enable_q <= 1'b0;
         compare_data_q <= '0;
      end else begin
         unique case (state_q)
            StInit: begin
               if (!cam_write_busy) begin
                  req_ready_q <= 1'b1;
                  state_q     <= StIdle;
               end
            end
            StIdle: begin
               if (req_valid) begin
                  key_q          <= req_data;
                  op_q           <= req_op;
                  compare_data_q <= req_data;
                  req_ready_q    <= 1'b0;
                  state_q        <= StLookup;
               end
            end
            StLookup: state_q <= StEval;
            StEval: begin
               if (op_q == OP_DELETE) begin
                  if (cam_match) begin
                     write_addr_q   <= cam_match_addr;
                     write_data_q   <= key_q;
                     write_delete_q <= 1'b1;
                     state_q        <= StWrite;
                  end else begin
                     resp_status_q <= ST_NOT_FOUND;
                     resp_addr_q   <= '0;
                     resp_valid_q  <= 1'b1;
                     state_q       <= StResp;
                  end
               end else if (dup_hit) begin
                  resp_status_q <= ST_EXISTS;
                  resp_addr_q   <= cam_match_addr;
                  resp_valid_q  <= 1'b1;
                  state_q       <= StResp;
               end else if (full) begin
                  resp_status_q <= ST_FULL;
                  resp_addr_q   <= '0;
                  resp_valid_q  <= 1'b1;
                  state_q       <= StResp;
               end else begin
                  write_addr_q   <= free_idx;
                  write_data_q   <= key_q;
                  write_delete_q <= 1'b0;
                  state_q        <= StWrite;
               end
            end
            StWrite: begin
               if (!cam_write_busy) begin
                  write_enable_q <= 1'b1;
                  wait_first_q   <= 1'b1;
                  state_q        <= StWait;
               end
            end
            StWait: begin
               // Busy lags enable by a cycle, so the first WAIT cycle never looks at it.
               write_enable_q <= 1'b0;
               wait_first_q   <= 1'b0;
               if (!wait_first_q && !cam_write_busy) begin
                  bitmap_q[write_addr_q] <= (op_q == OP_INSERT);
                  if (op_q == OP_INSERT) begin
                     occupancy_q <= occupancy_q + OccW'(1);
                  end else begin
                     occupancy_q <= occupancy_q - OccW'(1);
                  end
                  resp_status_q <= ST_INSERTED;
                  resp_addr_q   <= write_addr_q;
                  resp_valid_q  <= 1'b1;
                  state_q       <= StResp;
               end
            end
            StResp: begin
               if (resp_ready) begin
                  resp_valid_q <= 1'b0;
                  req_ready_q  <= 1'b1;
                  state_q      <= StIdle;
               end
            end
            default: state_q <= StInit;
         endcase
      end
   end

   assign req_ready        = req_ready_q;
   assign resp_valid       = resp_valid_q;
   assign resp_status      = resp_status_q;
   assign resp_addr        = resp_addr_q;
   assign occupancy        = occupancy_q;
   assign cam_write_addr   = write_addr_q;
   assign cam_write_data   = write_data_q;
   assign cam_write_delete = write_delete_q;
   assign cam_write_enable = write_enable_q;
   assign cam_compare_data = compare_data_q;

endmodule

// File: doc/cam_table_ctrl.md
# cam_table_ctrl

Request controller for the block-RAM CAM. Accepts insert and delete commands on a valid/ready port and keeps an occupancy bitmap of CAM entries. For each command it sequences a CAM lookup, the CAM write port, and free-entry allocation, then returns a single response per command. It sits between packet-level clients (flow or MAC tables) and the CAM, and is the only driver of the CAM's write and compare ports.

## Interface
- DATA_WIDTH, 64, key width; equals the CAM's DATA_WIDTH
- ADDR_WIDTH, 5, log2 of CAM depth; equals the CAM's ADDR_WIDTH
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset; synchronous, active-high
- req_data  in  DATA_WIDTH  key
- req_op  in  1  0 = insert, 1 = delete
- req_valid  in  1  command valid
- req_ready  out  1  command accepted on valid&&ready
- resp_addr  out  ADDR_WIDTH  entry index acted on (0 when status is FULL or NOT_FOUND)
- resp_status  out  2  0 INSERTED, 1 EXISTS, 2 FULL, 3 NOT_FOUND
- resp_valid  out  1  response valid; held until resp_ready
- resp_ready  in  1  response consumed
- occupancy  out  ADDR_WIDTH+1  number of valid entries
- cam_write_addr / cam_write_data / cam_write_delete / cam_write_enable  out  ADDR_WIDTH / DATA_WIDTH / 1 / 1  CAM write port
- cam_write_busy  in  1  CAM write busy
- cam_compare_data  out  DATA_WIDTH  CAM search key
- cam_match, cam_match_addr  in  1, ADDR_WIDTH  CAM lowest-index match result

## Operation
- States: INIT, IDLE, LOOKUP, EVAL, WRITE, WAIT, RESP.
- **INIT** (entered on reset): wait until cam_write_busy is low, which ends the CAM zeroing pass, then go to IDLE.
- **IDLE**: req_ready = 1. On handshake, register key and op, drive cam_compare_data with the key, go to LOOKUP.
- **LOOKUP**: one wait cycle while the CAM RAM reads.
- **EVAL**: sample cam_match and cam_match_addr.
  - Insert with match: status EXISTS, addr = match_addr, go to RESP.
  - Insert, no match, bitmap full: status FULL, go to RESP.
  - Insert, no match, space free: allocate the lowest-index clear bitmap bit, go to WRITE with cam_write_delete = 0.
  - Delete with match: target = match_addr, go to WRITE with cam_write_delete = 1.
  - Delete, no match: status NOT_FOUND, go to RESP.
- **WRITE**: pulse cam_write_enable for exactly one cycle, only when cam_write_busy is low; otherwise stay in WRITE. Go to WAIT.
- **WAIT**: ignore cam_write_busy in the first WAIT cycle, because busy asserts one cycle after enable. Then wait for busy low. On exit:
  - set the bitmap bit (status INSERTED) or clear it (status INSERTED is not used for delete: report status 0 with addr = deleted index);
  - update occupancy in the same cycle;
  - go to RESP.
- **RESP**: resp_valid = 1 and outputs held stable; return to IDLE on resp_ready.
- Only one command is outstanding at a time, so a lookup never overlaps a CAM write.
- occupancy equals the popcount of the bitmap. It is maintained incrementally (+1 / −1) and never wraps. Its maximum is 2**ADDR_WIDTH, which is why it is ADDR_WIDTH+1 bits wide.

## Timing
- Reset values:
  - req_ready 0, resp_valid 0, resp_status 0, resp_addr 0, occupancy 0;
  - cam_write_enable 0, cam_write_delete 0;
  - cam_write_addr 0, cam_write_data 0, cam_compare_data 0;
  - bitmap all clear.
- Reset mid-operation: return to INIT from any state and drop any pending response. Since the CAM is reset together with this block, the bitmap clear stays consistent.
- Latency from request handshake to resp_valid:
  - lookup-only outcomes: 3 cycles (LOOKUP, EVAL, RESP);
  - writes: 3 cycles + CAM write time, 5 cycles for an idle CAM on delete, 7 on insert.
- req_ready falls in the cycle after the accepting handshake.
- Back-to-back: a new request can be accepted in the cycle after the resp handshake.
- All CAM outputs are registered. cam_write_addr and cam_write_data are stable from WRITE through WAIT.

## Configuration
- CAM_CTRL_DUP_CHECK_EN defined: insert behaves as described above.
- Undefined: insert skips the match check and never returns EXISTS. EVAL uses only the bitmap, and duplicate keys may occupy several entries. Delete still uses the lookup and removes the lowest-index match.

## Structure
- Shared package `cam_pkg`:
  - op encodings (OP_INSERT, OP_DELETE);
  - status encodings (ST_INSERTED, ST_EXISTS, ST_FULL, ST_NOT_FOUND);
  - state enum.
- Sub-module `cam_free_alloc`: combinational lowest-clear-bit finder over the bitmap, giving a free index plus a `full` flag. Reuse the codebase priority_encoder on the inverted bitmap.

## Test plan
- Reset, hold CAM busy 512 cycles → req_ready stays 0 until busy falls, then 1; occupancy 0.
- Insert 0x1234 → INSERTED, addr 0, occupancy 1. Insert 0x1234 again → EXISTS, addr 0, occupancy 1. Without the macro, the second insert gives INSERTED, addr 1.
- Insert 32 distinct keys, then a 33rd → 33rd returns FULL, addr 0, no cam_write_enable pulse, occupancy 32.
- Delete the key at index 5, then insert a new key → delete reports addr 5; the insert is placed at addr 5 (lowest free); occupancy unchanged overall.
- Delete unknown 0xDEAD → NOT_FOUND within 3 cycles, with no write pulse. Hold resp_ready low 10 cycles → resp outputs stable and req_ready 0 throughout.
- Assert rst during WAIT of an insert → all outputs return to reset values next cycle, bitmap cleared, controller re-enters INIT.
